// File: rtl/uart_word_tx_if.sv
// uart_word_tx_if: word handshake between the frame FIFO side and the UART
// word transmitter.
// Handshake: a word moves on a rising clk edge where tx_vld && tx_rdy.
// tx_data only needs to be stable on that edge. tx_vld while tx_rdy is low is
// ignored. tx_done pulses for one cycle in the final cycle of the last stop bit.
interface uart_word_tx_if #(
    parameter int DATA_BYTE_WIDTH = 8
);
    logic [DATA_BYTE_WIDTH*8-1:0] tx_data;
    logic                         tx_vld;
    logic                         tx_rdy;
    logic                         tx_done;

    modport master (
        output tx_data,
        output tx_vld,
        input  tx_rdy,
        input  tx_done
    );

    modport slave (
        input  tx_data,
        input  tx_vld,
        output tx_rdy,
        output tx_done
    );
endinterface

// File: rtl/uart_word_tx.sv
// uart_word_tx: accepts one DATA_BYTE_WIDTH-byte word and sends it as
// back-to-back 8N1 frames, least-significant byte first.
// Optional feature macro UART_TX_PARITY_EN: adds an even-parity bit after the
// data bits, so each byte takes 11 bit-times instead of 10.
// tx_rdy and tx_done are raised in the last cycle of the final stop bit. A
// waiting word is then taken on the edge that ends that stop bit, and its
// start bit follows with no idle cycle.
// CYCLES_PER_BIT must be at least 2.
module uart_word_tx #(
    parameter int CLK_FRE         = 50,
    parameter int BAUD_RATE       = 38400,
    parameter int DATA_BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_word_tx_if.slave         bus,
    output logic                  uart_tx,
    output logic [2:0]            dbg_state
);
    localparam int CYCLES_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int BAUD_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int BYTE_W = $clog2(DATA_BYTE_WIDTH) + 1;
    localparam int DATA_W = DATA_BYTE_WIDTH * 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                uart_tx_q, uart_tx_d;
    logic                tx_rdy_q, tx_rdy_d;
    logic                tx_done_q, tx_done_d;

    logic                accept;
    logic                bit_end;
    logic                pre_end;
    logic                last_byte;
    logic [7:0]          cur_byte;
    logic [2:0]          nxt_bit;

    assign accept    = bus.tx_vld && tx_rdy_q;
    assign bit_end   = (baud_q == BAUD_W'(CYCLES_PER_BIT - 1));
    assign pre_end   = (baud_q == BAUD_W'(CYCLES_PER_BIT - 2));
    assign last_byte = (byte_cnt_q == BYTE_W'(DATA_BYTE_WIDTH - 1));
    assign cur_byte  = shift_q[7:0];
    assign nxt_bit   = bit_cnt_q + 3'd1;

    // Next-state and next-output computation for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        uart_tx_d  = uart_tx_q;
        tx_rdy_d   = tx_rdy_q;
        tx_done_d  = 1'b0;

        if (state_q == IDLE) begin
            baud_d = '0;
        end else begin
            baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            IDLE: begin
                uart_tx_d = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                    uart_tx_d = cur_byte[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        uart_tx_d = ^cur_byte;
`else
                        state_d   = STOP;
                        uart_tx_d = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = nxt_bit;
                        uart_tx_d = cur_byte[nxt_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d   = STOP;
                    uart_tx_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (last_byte && pre_end) begin
                    tx_done_d = 1'b1;
                    tx_rdy_d  = 1'b1;
                end
                if (bit_end) begin
                    if (!last_byte) begin
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        shift_d    = shift_q >> 8;
                        state_d    = START;
                        uart_tx_d  = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        uart_tx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                uart_tx_d = 1'b1;
                tx_rdy_d  = 1'b1;
            end
        endcase

        // A new word overrides whatever the sequencer was about to do.
        if (accept) begin
            state_d    = START;
            shift_d    = bus.tx_data;
            byte_cnt_d = '0;
            bit_cnt_d  = 3'd0;
            baud_d     = '0;
            uart_tx_d  = 1'b0;
            tx_rdy_d   = 1'b0;
        end
    end

    // State, counters and all outputs are registered; reset forces an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_rdy_q   <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_rdy_q   <= tx_rdy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign uart_tx     = uart_tx_q;
    assign bus.tx_rdy  = tx_rdy_q;
    assign bus.tx_done = tx_done_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed words into uart_word_tx, serial line decoded by a
// monitor and scored against the words queued by the stimulus.
module tb_uart_word_tx;
    localparam int CPB = 10;
    localparam int NB  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int WORD_CYC = NB * BITS * CPB;

    logic       clk;
    logic       rst;
    logic       uart_tx;
    logic [2:0] dbg_state;

    uart_word_tx_if #(.DATA_BYTE_WIDTH(NB)) bus_if();

    uart_word_tx #(
        .CLK_FRE(1),
        .BAUD_RATE(100000),
        .DATA_BYTE_WIDTH(NB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if),
        .uart_tx(uart_tx),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [NB*8-1:0] exp_q[$];
    int              gap_q[$];
    int              checks = 0;
    int              errors = 0;
    int              pushed = 0;
    int              seen   = 0;
    logic            mon_on = 1'b1;
    logic            mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_rdy();
        int t = 0;
        while (bus_if.tx_rdy !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("rdy_wait", bus_if.tx_rdy, 1);
    endtask

    task automatic send_word(input logic [NB*8-1:0] w, input int gap);
        wait_rdy();
        bus_if.tx_data = w;
        bus_if.tx_vld  = 1'b1;
        exp_q.push_back(w);
        gap_q.push_back(gap);
        pushed++;
        @(negedge clk);
        check("accept_line_low", uart_tx, 0);
        check("accept_rdy_low", bus_if.tx_rdy, 0);
        bus_if.tx_vld  = 1'b0;
        bus_if.tx_data = 16'hDEAD;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 1500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        int               gap;
        int               gap_at_start;
        int               wgap;
        int               unstable;
        int               done_cnt;
        int               done_pos;
        int               rdy_bad;
        logic             aborted;
        logic             bitv;
        logic [NB*BITS-1:0] bits_rx;
        logic [NB*8-1:0]  got;
        logic [NB*8-1:0]  want;
        gap = 0;
        bitv = 1'b1;
        forever begin
            @(negedge clk);
            if (rst || !mon_on) begin
                gap = 0;
                continue;
            end
            if (uart_tx === 1'b1) begin
                gap++;
                continue;
            end
            mon_busy = 1'b1;
            gap_at_start = gap;
            aborted = 1'b0;
            unstable = 0;
            done_cnt = 0;
            done_pos = -1;
            rdy_bad = 0;
            bits_rx = '0;
            for (int c = 0; c < WORD_CYC; c++) begin
                if (c != 0) @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (c % CPB == 0) begin
                    bitv = uart_tx;
                    bits_rx[c / CPB] = uart_tx;
                end else if (uart_tx !== bitv) begin
                    unstable++;
                end
                if (bus_if.tx_done === 1'b1) begin
                    done_cnt++;
                    done_pos = c;
                end
                if (bus_if.tx_rdy !== (c == WORD_CYC - 1)) rdy_bad++;
            end
            if (!aborted) begin
                seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_word", exp_q.size(), 1);
                end else begin
                    want = exp_q.pop_front();
                    wgap = gap_q.pop_front();
                    got = '0;
                    for (int b = 0; b < NB; b++) begin
                        got[b*8 +: 8] = bits_rx[b*BITS+1 +: 8];
                        check($sformatf("start_bit_%0d", b), bits_rx[b*BITS], 0);
                        check($sformatf("stop_bit_%0d", b), bits_rx[b*BITS+BITS-1], 1);
`ifdef UART_TX_PARITY_EN
                        check($sformatf("parity_bit_%0d", b), bits_rx[b*BITS+9], ^want[b*8 +: 8]);
`endif
                    end
                    check("word_data", got, want);
                    check("bit_period_stable", unstable, 0);
                    check("done_pulse_count", done_cnt, 1);
                    check("done_position", done_pos, WORD_CYC - 1);
                    check("rdy_during_word", rdy_bad, 0);
                    if (wgap >= 0) check("inter_word_gap", gap_at_start, wgap);
                end
            end
            gap = 0;
            mon_busy = 1'b0;
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int lows;
        rst = 1'b1;
        bus_if.tx_vld = 1'b0;
        bus_if.tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_tx_rdy", bus_if.tx_rdy, 1);
        check("reset_tx_done", bus_if.tx_done, 0);
        check("reset_state", dbg_state, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word: 0x01 then 0xA5 on the line.
        send_word(16'hA501, -1);
        drain();

        // Requests and data changes while busy are ignored.
        send_word(16'h3C5A, -1);
        repeat (20) @(negedge clk);
        bus_if.tx_data = 16'hBEEF;
        bus_if.tx_vld  = 1'b1;
        @(negedge clk);
        bus_if.tx_vld  = 1'b0;
        repeat (40) @(negedge clk);
        bus_if.tx_data = 16'h0000;
        bus_if.tx_vld  = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.tx_vld  = 1'b0;
        drain();

        // Back-to-back with tx_vld held high.
        wait_rdy();
        bus_if.tx_data = 16'h1234;
        bus_if.tx_vld  = 1'b1;
        exp_q.push_back(16'h1234);
        gap_q.push_back(-1);
        pushed++;
        @(negedge clk);
        check("b2b_first_low", uart_tx, 0);
        bus_if.tx_data = 16'h5678;
        exp_q.push_back(16'h5678);
        gap_q.push_back(0);
        pushed++;
        begin
            int t = 0;
            while (bus_if.tx_done !== 1'b1 && t < 1000) begin
                @(negedge clk);
                t++;
            end
        end
        check("b2b_done_seen", bus_if.tx_done, 1);
        check("b2b_rdy_with_done", bus_if.tx_rdy, 1);
        @(negedge clk);
        check("b2b_second_start", uart_tx, 0);
        check("b2b_second_rdy_low", bus_if.tx_rdy, 0);
        bus_if.tx_vld = 1'b0;
        drain();

        // Parity word, then all-ones and all-zeros framing.
        send_word(16'h0703, -1);
        drain();
        send_word(16'hFFFF, -1);
        drain();
        send_word(16'h0000, -1);
        drain();

        // Reset in the middle of a start bit aborts the word.
        mon_on = 1'b0;
        send_word(16'h00FF, -1);
        void'(exp_q.pop_back());
        void'(gap_q.pop_back());
        pushed--;
        repeat (3) @(negedge clk);
        check("pre_reset_line_low", uart_tx, 0);
        rst = 1'b1;
        #1;
        check("async_reset_uart_tx", uart_tx, 1);
        check("async_reset_tx_rdy", bus_if.tx_rdy, 1);
        check("async_reset_tx_done", bus_if.tx_done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        check("no_resume_after_reset", lows, 0);
        check("idle_state_after_reset", dbg_state, 0);
        mon_on = 1'b1;
        @(negedge clk);

        // Normal operation after the abort.
        send_word(16'h55AA, -1);
        drain();

        check("words_seen", seen, pushed);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
